// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   - AXI read-response codes
//   - default halt sentinel
//   - fetch FSM state encoding
//   - fetch_entry_t: one buffered instruction tagged with its byte address
package cpu_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_ADDR,
    ST_DATA,
    ST_HALT,
    ST_ERR
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head.
//   clk, rst   : clock, asynchronous active-high reset
//   flush_i    : empties the FIFO on the next edge (wins over push/pop)
//   push_i     : write wdata_i (accepted when not full, or when popping)
//   pop_i      : drop the head entry (ignored when empty)
//   rdata_o    : head entry, driven straight from the storage registers
//   full_o, empty_o, count_o : occupancy status
module sync_fifo #(
  parameter int unsigned WIDTH = 52,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, wptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is legal only alongside a pop.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_axi.sv
// AXI4-Lite read master fetching instruction words from BRAM.
//   clk, rst                    : clock, asynchronous active-high reset
//   start                       : level, begins fetching (sampled in IDLE)
//   redirect_valid/redirect_pc  : load a new PC and flush buffered words
//   araddr/arvalid/arready      : AXI read-address channel
//   rdata/rresp/rvalid/rready   : AXI read-data channel
//   inst_valid/inst_ready       : buffered instruction handshake
//   inst/inst_pc                : head instruction and its byte address
//   halted                      : halt sentinel reached (cleared by redirect)
//   error                       : non-OKAY response seen (cleared by reset)
module inst_fetch_axi
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 20,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(HALT_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted,
  output logic              error
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] req_q, req_d;
  logic              drop_q, drop_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;

  logic              redir;
  logic [ADDR_W-1:0] redir_pc;
  logic              push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, cnt_after;
  logic [DATA_W+ADDR_W-1:0] fifo_head;
  logic              unused_pc_lsbs;

  assign redir          = redirect_valid && (state_q != ST_ERR);
  assign redir_pc       = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign pop            = !fifo_empty && inst_ready;
  assign cnt_after      = fifo_count + CW'(1) - CW'(pop);

  sync_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i ({rdata, req_q}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      araddr_q <= RESET_PC;
      req_q    <= '0;
      drop_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      araddr_q <= araddr_d;
      req_q    <= req_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    drop_d   = drop_q;
    halted_d = halted_q;
    error_d  = error_q;
    push     = 1'b0;
    flush    = 1'b0;
    araddr_d = araddr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ADDR;
      end
      ST_WAIT_SPACE: begin
        if (!fifo_full) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        // A redirect here cannot retract the issued address; the read
        // completes and its word is discarded via the drop flag.
        if (redir) drop_d = 1'b1;
        if (arready) begin
          req_d   = araddr_q;
          state_d = ST_DATA;
          if (!drop_q && !redir) pc_d = pc_q + ADDR_W'(4);
        end
      end
      ST_DATA: begin
        if (redir) drop_d = 1'b1;
        if (rvalid) begin
          // The outstanding read retires now, so nothing is left to drop.
          drop_d = 1'b0;
          if (rresp != RESP_OKAY) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else if (drop_q || redir) begin
            state_d = ST_ADDR;
          end else if (rdata == HALT_WORD) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = (cnt_after < CW'(FIFO_DEPTH)) ? ST_ADDR : ST_WAIT_SPACE;
          end
        end
      end
      ST_HALT: begin
        if (redir) begin
          halted_d = 1'b0;
          state_d  = ST_ADDR;
        end
      end
      ST_ERR: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (redir) begin
      pc_d  = redir_pc;
      flush = 1'b1;
    end
    if (state_d == ST_ERR) flush = 1'b1;

    // araddr must stay put while a request waits for arready.
    if (!(state_q == ST_ADDR && !arready)) araddr_d = pc_d;
  end

  always_comb begin
    arvalid    = (state_q == ST_ADDR);
    rready     = (state_q == ST_DATA);
    araddr     = araddr_q;
    inst_valid = !fifo_empty;
    inst       = fifo_head[DATA_W+ADDR_W-1:ADDR_W];
    inst_pc    = fifo_head[ADDR_W-1:0];
    halted     = halted_q;
    error      = error_q;
  end

endmodule

// File: tb/tb_inst_fetch_axi.sv
module tb_inst_fetch_axi;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        redirect_valid;
  logic [19:0] redirect_pc;
  logic [19:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [19:0] inst_pc;
  logic        halted;
  logic        error;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  inst_fetch_axi #(
    .ADDR_W     (20),
    .DATA_W     (32),
    .FIFO_DEPTH (2),
    .RESET_PC   (20'h00000),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .halted         (halted),
    .error          (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // ---------------- BRAM image and slave model ----------------
  logic [31:0]  mem [int unsigned];
  logic [19:0]  issued [$];
  fetch_entry_t got_q [$];
  fetch_entry_t exp_q [$];
  logic [19:0]  exp_halt_pc;

  int unsigned lat_min = 0, lat_max = 3, arr_pct = 70;
  int unsigned rd_cnt = 0, err_on = 0;

  function automatic logic [31:0] mem_rd(input logic [19:0] a);
    int unsigned k;
    k = {12'd0, a};
    if (mem.exists(k)) return mem[k];
    return 32'h0000_0013;
  endfunction

  // Reference: the instruction stream is the word sequence from the start
  // PC up to (not including) the first halt sentinel, addresses mod 2^20.
  function automatic void model(input logic [19:0] spc);
    logic [19:0] pc;
    logic [31:0] w;
    exp_q.delete();
    pc = spc;
    for (int n = 0; n < 64; n++) begin
      w = mem_rd(pc);
      if (w == HALT_WORD_DEFAULT) break;
      exp_q.push_back('{inst: w, pc: pc});
      pc = pc + 20'd4;
    end
    exp_halt_pc = pc;
  endfunction

  initial begin
    bit          pend, ar_fire, r_fire;
    logic [19:0] s_addr;
    int unsigned s_lat;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    pend = 0; ar_fire = 0; r_fire = 0; s_addr = '0; s_lat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; rresp = '0;
        pend = 0; ar_fire = 0; r_fire = 0;
      end else begin
        if (r_fire) begin
          rvalid = 1'b0; rresp = '0; pend = 0; r_fire = 0;
        end
        if (ar_fire) begin
          pend = 1; ar_fire = 0; rd_cnt++;
          s_lat = $urandom_range(lat_max, lat_min);
        end
        arready = !pend && ($urandom_range(99, 0) < arr_pct);
        if (arvalid && arready) begin
          ar_fire = 1; s_addr = araddr; issued.push_back(araddr);
        end
        if (pend && !rvalid) begin
          if (s_lat == 0) begin
            rvalid = 1'b1;
            rdata  = mem_rd(s_addr);
            rresp  = (rd_cnt == err_on) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            s_lat--;
          end
        end
        if (rvalid && rready) r_fire = 1;
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    if (!rst && inst_valid && inst_ready && !redirect_valid)
      got_q.push_back('{inst: inst, pc: inst_pc});
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 0; redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    issued.delete(); got_q.delete(); mem.delete();
    rd_cnt = 0; err_on = 0; lat_min = 0; lat_max = 3; arr_pct = 70;
  endtask

  task automatic run_until_halt(input int unsigned budget, input bit rnd, output bit ok);
    ok = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      inst_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      tick();
      if (halted && !inst_valid) begin ok = 1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    start = 0; redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
    rst = 1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({arvalid, rready, inst_valid, halted, error} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, want 00000", {arvalid, rready, inst_valid, halted, error});
    end
    n_cmp++;
    if ({araddr, inst, inst_pc} !== {20'h00000, 32'h0, 20'h0}) begin
      n_err++;
      $display("FAIL reset_data: araddr=%h inst=%h inst_pc=%h, want 00000/0/0", araddr, inst, inst_pc);
    end
    do_reset();
  endtask

  task automatic load_basic();
    mem[32'h0] = 32'h0050_0093;
    mem[32'h4] = 32'h0010_0113;
    mem[32'h8] = 32'hFFFF_FFFF;
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    load_basic();
    model(20'h0);
    start = 1;
    run_until_halt(300, 0, ok);
    repeat (10) tick();
    n_cmp++;
    if (!ok || halted !== 1'b1) begin
      n_err++; $display("FAIL basic_halt: ok=%0d halted=%b, want 1/1", ok, halted);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL basic_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL basic_word[%0d]: got %h@%h, want %h@%h", i, got_q[i].inst, got_q[i].pc, exp_q[i].inst, exp_q[i].pc);
      end
    end
    n_cmp++;
    if (issued.size() != 3 || issued[0] !== 20'h0 || issued[1] !== 20'h4 || issued[2] !== 20'h8) begin
      n_err++; $display("FAIL basic_reads: %0d reads issued (last %h), want 3 ending at 00008", issued.size(), issued.size() ? issued[$] : 20'h0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    load_basic();
    model(20'h0);
    start = 1; inst_ready = 0;
    repeat (20) tick();
    n_cmp++;
    if (issued.size() != 2 || inst_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_reads_before_pop: reads=%0d inst_valid=%b, want 2/1", issued.size(), inst_valid);
    end
    run_until_halt(300, 0, ok);
    n_cmp++;
    if (!ok || issued.size() != 3 || issued[2] !== 20'h8) begin
      n_err++; $display("FAIL bp_third_read: ok=%0d reads=%0d, want 1/3 with third 00008", ok, issued.size());
    end
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      n_err++; $display("FAIL bp_stream: got %0d words, want 2 in order 0/4", got_q.size());
    end
  endtask

  task automatic test_redirect();
    bit ok, seen;
    do_reset();
    mem[32'h00] = 32'h1111_0001;
    mem[32'h04] = 32'h2222_0002;
    mem[32'h14] = 32'h3333_0003;
    mem[32'h18] = 32'h4444_0004;
    mem[32'h1C] = 32'hFFFF_FFFF;
    lat_min = 3; lat_max = 3; arr_pct = 100;
    start = 1; inst_ready = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (rready && issued.size() == 2) begin seen = 1; break; end
      tick();
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL redir_reach_data: DATA for 00004 not seen, want seen");
    end
    redirect_valid = 1; redirect_pc = 20'h00015;
    tick();
    redirect_valid = 0;
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_flush: inst_valid=%b, want 0", inst_valid);
    end
    model(20'h14);
    run_until_halt(300, 0, ok);
    n_cmp++;
    if (!ok || issued.size() != 5 || issued[2] !== 20'h14) begin
      n_err++; $display("FAIL redir_next_addr: ok=%0d reads=%0d third=%h, want 1/5/00014", ok, issued.size(), issued.size() > 2 ? issued[2] : 20'h0);
    end
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      n_err++; $display("FAIL redir_stream: got %0d words first pc %h, want 2 words from 00014", got_q.size(), got_q.size() ? got_q[0].pc : 20'h0);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    mem[32'hFFFFC] = 32'hABCD_0001;
    mem[32'h00000] = 32'hABCD_0002;
    mem[32'h00004] = 32'hFFFF_FFFF;
    redirect_valid = 1; redirect_pc = 20'hFFFFE;
    tick();
    redirect_valid = 0; start = 1;
    model(20'hFFFFC);
    run_until_halt(300, 1, ok);
    n_cmp++;
    if (!ok || issued.size() != 3 || issued[0] !== 20'hFFFFC || issued[1] !== 20'h00000) begin
      n_err++; $display("FAIL wrap_addr: ok=%0d reads=%0d second=%h, want 1/3/00000", ok, issued.size(), issued.size() > 1 ? issued[1] : 20'hFFFFF);
    end
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      n_err++; $display("FAIL wrap_stream: got %0d words, want 2 (FFFFC then 00000)", got_q.size());
    end
  endtask

  task automatic test_error();
    bit seen;
    int unsigned bad;
    do_reset();
    mem[32'h0] = 32'hAAAA_0000; mem[32'h4] = 32'hBBBB_0004;
    mem[32'h8] = 32'hCCCC_0008; mem[32'hC] = 32'hFFFF_FFFF;
    err_on = 2;
    start = 1; inst_ready = 1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (error) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL err_flag: error=%b after 100 cycles, want 1", error);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (arvalid || rready || inst_valid || !error) bad++;
      redirect_valid = (i == 10); redirect_pc = 20'h40;
      inst_ready = 1'($urandom_range(1, 0));
      tick();
    end
    redirect_valid = 0;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL err_sticky: %0d cycles with activity or error low, want 0", bad);
    end
    n_cmp++;
    if (issued.size() != 2 || got_q.size() != 1 || got_q[0].pc !== 20'h0 || got_q[0].inst !== 32'hAAAA_0000) begin
      n_err++; $display("FAIL err_stream: reads=%0d words=%0d, want 2 reads and 1 word AAAA0000@00000", issued.size(), got_q.size());
    end
    do_reset();
    n_cmp++;
    if (error !== 1'b0) begin
      n_err++; $display("FAIL err_clear: error=%b after reset, want 0", error);
    end
  endtask

  task automatic test_reset_midstream();
    bit ok, seen;
    do_reset();
    for (int unsigned i = 0; i < 16; i++) mem[i*4] = 32'h5000_0000 + i;
    mem[64] = 32'hFFFF_FFFF;
    start = 1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      inst_ready = 1'($urandom_range(1, 0));
      if (issued.size() >= 5 && arvalid) begin seen = 1; break; end
      tick();
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL mid_reach: arvalid mid-stream not seen, want seen");
    end
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({arvalid, rready, inst_valid, halted, error, inst, inst_pc, araddr} !== {5'b0, 32'h0, 20'h0, 20'h0}) begin
      n_err++;
      $display("FAIL mid_async_reset: ctrl=%b inst=%h pc=%h araddr=%h, want all 0", {arvalid, rready, inst_valid, halted, error}, inst, inst_pc, araddr);
    end
    start = 0; inst_ready = 0;
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    issued.delete(); got_q.delete(); rd_cnt = 0;
    repeat (5) tick();
    n_cmp++;
    if (arvalid !== 1'b0 || issued.size() != 0) begin
      n_err++; $display("FAIL mid_idle: arvalid=%b reads=%0d before start, want 0/0", arvalid, issued.size());
    end
    model(20'h0);
    start = 1;
    run_until_halt(1000, 1, ok);
    n_cmp++;
    if (!ok || issued.size() != exp_q.size() + 1 || issued[0] !== 20'h0) begin
      n_err++; $display("FAIL mid_restart: ok=%0d reads=%0d first=%h, want 1/%0d/00000", ok, issued.size(), issued.size() ? issued[0] : 20'hFFFFF, exp_q.size() + 1);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL mid_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL mid_word[%0d]: got %h@%h, want %h@%h", i, got_q[i].inst, got_q[i].pc, exp_q[i].inst, exp_q[i].pc);
      end
    end
  endtask

  task automatic test_random();
    logic [19:0]  base;
    logic [31:0]  w;
    int unsigned  n;
    bit           held, done;
    fetch_entry_t held_e;
    int unsigned  unstable;
    for (int it = 0; it < 5; it++) begin
      do_reset();
      arr_pct = $urandom_range(100, 30);
      lat_max = $urandom_range(4, 0);
      base = (it == 0) ? 20'hFFFF0 : (20'($urandom_range(32'hFFFFF, 0)) & 20'hFFFFC);
      n = $urandom_range(10, 1);
      for (int unsigned i = 0; i < n; i++) begin
        w = $urandom;
        if (w == HALT_WORD_DEFAULT) w = 32'h0;
        mem[{12'd0, base + 20'(i * 4)}] = w;
      end
      mem[{12'd0, base + 20'(n * 4)}] = HALT_WORD_DEFAULT;
      model(base);
      redirect_valid = 1; redirect_pc = base | 20'($urandom_range(3, 0));
      tick();
      redirect_valid = 0; start = 1;
      held = 0; unstable = 0; done = 0;
      for (int c = 0; c < 600; c++) begin
        if (held && inst_valid && ({inst, inst_pc} !== held_e)) unstable++;
        inst_ready = 1'($urandom_range(1, 0));
        held = inst_valid && !inst_ready;
        held_e = '{inst: inst, pc: inst_pc};
        tick();
        if (halted && !inst_valid) begin done = 1; break; end
      end
      n_cmp++;
      if (!done || unstable != 0) begin
        n_err++; $display("FAIL rand%0d_progress: done=%0d unstable=%0d, want 1/0", it, done, unstable);
      end
      n_cmp++;
      if (issued.size() != exp_q.size() + 1 || (issued.size() != 0 && issued[$] !== exp_halt_pc)) begin
        n_err++; $display("FAIL rand%0d_reads: reads=%0d, want %0d ending at %h", it, issued.size(), exp_q.size() + 1, exp_halt_pc);
      end
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL rand%0d_count: got %0d words, want %0d", it, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rand%0d_word[%0d]: got %h@%h, want %h@%h", it, i, got_q[i].inst, got_q[i].pc, exp_q[i].inst, exp_q[i].pc);
        end
      end
    end
  endtask

  initial begin
    rst = 1; start = 0; redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_error();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_axi.md
Name: inst_fetch_axi

Overview:
- AXI4-Lite read master that streams 32-bit instruction words out of the instruction BRAM (AXI BRAM controller, 20-bit byte address) into the control unit.
- Keeps a PC, issues one read at a time, and buffers returned words in a small FIFO.
- Presents the buffered words to the control unit on a valid/ready port, each tagged with its PC.
- Stops at the halt sentinel word, supports PC redirect (branch/jump) with flush, and flags bus errors.

Parameters:
- ADDR_W, 20, AXI byte-address width.
- DATA_W, 32, instruction/data width.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.
- RESET_PC, 20'h00000, PC value after reset.
- HALT_WORD, 32'hFFFFFFFF, sentinel word that ends fetching.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; begin fetching from the current PC
- redirect_valid  in  1  one-cycle pulse; load new PC and flush
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored
- araddr  out  ADDR_W  AXI read address
- arvalid  out  1  AXI read-address valid
- arready  in  1  AXI read-address ready
- rdata  in  DATA_W  AXI read data
- rresp  in  2  AXI read response
- rvalid  in  1  AXI read-data valid
- rready  out  1  AXI read-data ready
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  consumer accepts the head
- inst  out  DATA_W  head instruction word
- inst_pc  out  ADDR_W  byte address of the head instruction
- halted  out  1  HALT_WORD reached; sticky until redirect or reset
- error  out  1  rresp != OKAY seen; sticky until reset

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, except araddr=RESET_PC. PC=RESET_PC, FIFO empty, drop flag 0, state IDLE. Any AXI transaction in flight is abandoned; the BRAM controller is reset by the same rst.
- States: IDLE, WAIT_SPACE, ADDR, DATA, HALT, ERR.
- IDLE: go to ADDR when start=1.
- WAIT_SPACE: go to ADDR when FIFO occupancy < FIFO_DEPTH.
- ADDR:
  - arvalid=1 and araddr=PC, held stable until arready=1. arvalid never drops before the handshake.
  - On handshake: latch the request address, PC <= PC+4 (modulo 2^ADDR_W, so 20'hFFFFC wraps to 0), go to DATA.
- DATA: rready=1. Entry is only possible with a free FIFO slot. On rvalid:
  - rresp != 0: go to ERR; error=1 from the next cycle.
  - Drop flag set: discard the word, clear the flag, go to ADDR.
  - rdata == HALT_WORD: not pushed; go to HALT; halted=1 from the next cycle.
  - Otherwise: push {rdata, latched address}. Next state is ADDR if the FIFO will still have room after this cycle's push and pop, else WAIT_SPACE.
- HALT: no reads issued; the FIFO keeps draining normally.
- ERR: arvalid=0, rready=0, FIFO flushed, inst_valid=0. Left only by reset.
- Maximum one outstanding read. The address-to-data path is: arvalid, handshake, rvalid, then inst_valid on the cycle after the rvalid handshake (registered FIFO head).
- FIFO:
  - Pop when inst_valid && inst_ready.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
  - inst/inst_pc are stable while inst_valid=1 and inst_ready=0.
- Redirect (ignored in ERR):
  - Flushes the FIFO in the same edge, so inst_valid=0 next cycle.
  - PC <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - Redirect beats a coincident pop or push.
  - In ADDR before handshake: keep the current araddr (AXI stability), set the drop flag, and do not advance the PC from that handshake.
  - In DATA: set the drop flag.
  - In HALT: clear halted, go to ADDR.
  - In IDLE or WAIT_SPACE: only load the PC.
- start is sampled only in IDLE; deasserting it later does not stop fetching.

Decomposition:
- Shared package (cpu_pkg):
  - AXI response codes (RESP_OKAY=2'b00, RESP_SLVERR=2'b10).
  - HALT_WORD default.
  - Fetch-state enum.
  - fetch_entry_t struct {inst, pc}.
- One sub-module, sync_fifo: parameterised width/depth, registered head, flush input, full/empty/count outputs.

Test Plan:
- Preload BRAM words 0x00500093 @0x0, 0x00100113 @0x4, 0xFFFFFFFF @0x8; start=1, inst_ready=1 -> inst/inst_pc pairs (0x00500093, 0x0) then (0x00100113, 0x4); halted=1; no read issued after address 0x8.
- Same image with inst_ready=0 for 20 cycles -> exactly 2 reads issued; third araddr=0x8 appears only after the first pop; no word lost or duplicated.
- Redirect to 0x15 while in DATA for address 0x4 -> word @0x4 dropped, FIFO empty, next araddr=0x14, next inst_pc=0x14.
- PC at 0xFFFFC, word non-halt -> next araddr=0x00000.
- Slave returns rresp=2'b10 on the second read -> error=1, arvalid=0, inst_valid=0, and they stay so until rst.
- Assert rst for 1 cycle while arvalid=1 mid-stream -> all outputs 0 asynchronously, araddr=RESET_PC; fetch restarts from 0x0 on the next start.
